// File: rtl/bus_mux_reg_pkg.sv
// Shared bus definitions: default geometry, source index map and index-width helper.
package bus_pkg;

  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned BUS_NUM_SRC = 24;

  localparam int unsigned SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
  localparam int unsigned SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
  localparam int unsigned SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
  localparam int unsigned SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
  localparam int unsigned SRC_HI     = 16;
  localparam int unsigned SRC_LO     = 17;
  localparam int unsigned SRC_ZHIGH  = 18;
  localparam int unsigned SRC_ZLOW   = 19;
  localparam int unsigned SRC_PC     = 20;
  localparam int unsigned SRC_MDR    = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_CSE    = 23;

  // Source index width, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_mux_reg_if.sv
// Bus mux signal bundle: master drives enables/data, slave (the mux) returns bus and contention status.
interface bus_mux_reg_if
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH   = BUS_WIDTH,
  parameter int unsigned NUM_SRC = BUS_NUM_SRC,
  parameter int unsigned CNT_W   = 8
) ();

  localparam int unsigned IDX_W = idx_w(NUM_SRC);

  logic [NUM_SRC-1:0]       src_en;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic [IDX_W-1:0]         sel_idx;
  logic                     conflict;
  logic                     conflict_sticky;
  logic [NUM_SRC-1:0]       conflict_mask;
  logic [CNT_W-1:0]         conflict_count;

  modport master (
    output src_en, src_data,
    input  bus_out, bus_valid, sel_idx, conflict, conflict_sticky, conflict_mask, conflict_count
  );

  modport slave (
    input  src_en, src_data,
    output bus_out, bus_valid, sel_idx, conflict, conflict_sticky, conflict_mask, conflict_count
  );

endinterface

// File: rtl/bus_mux_reg_prio_enc.sv
// Highest-index-wins priority encoder over the source enable strobes.
module bus_prio_enc #(
  parameter int unsigned NUM_SRC = 24,
  parameter int unsigned IDX_W   = 5
) (
  input  logic [NUM_SRC-1:0] src_en,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Ascending scan: later (higher) hits overwrite earlier ones.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_en[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered CPU bus multiplexer with hold-on-idle and optional contention tracking
// (contention logic compiled in only when BUS_CONTENTION_CHECK_EN is defined).
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH   = BUS_WIDTH,
  parameter int unsigned NUM_SRC = BUS_NUM_SRC,
  parameter int unsigned CNT_W   = 8
) (
  input logic         clock,
  input logic         clear,
  bus_mux_reg_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_SRC);

  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [IDX_W-1:0] r_sel;

  bus_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .src_en (bus.src_en),
    .any    (w_any),
    .idx    (w_idx)
  );

  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (IDX_W'(i) == w_idx) w_word = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_bus   <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_bus <= w_word;
        r_sel <= w_idx;
      end
    end
  end

  assign bus.bus_out   = r_bus;
  assign bus.bus_valid = r_valid;
  assign bus.sel_idx   = r_sel;

`ifdef BUS_CONTENTION_CHECK_EN
  logic               w_multi;
  logic               r_conf;
  logic               r_sticky;
  logic [NUM_SRC-1:0] r_mask;
  logic [CNT_W-1:0]   r_cnt;

  assign w_multi = ($countones(bus.src_en) >= 2);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_conf   <= 1'b0;
      r_sticky <= 1'b0;
      r_mask   <= '0;
      r_cnt    <= '0;
    end else begin
      r_conf <= w_multi;
      if (w_multi) begin
        r_sticky <= 1'b1;
        if (!r_sticky) r_mask <= bus.src_en;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.conflict        = r_conf;
  assign bus.conflict_sticky = r_sticky;
  assign bus.conflict_mask   = r_mask;
  assign bus.conflict_count  = r_cnt;
`else
  assign bus.conflict        = 1'b0;
  assign bus.conflict_sticky = 1'b0;
  assign bus.conflict_mask   = '0;
  assign bus.conflict_count  = '0;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: a behavioural model pushes expected outputs per driven cycle.
module tb_bus_mux_reg;
  import bus_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 24;

  typedef struct {
    logic [W-1:0] bus;
    logic         valid;
    logic [4:0]   sel;
    logic         conf;
    logic         sticky;
    logic [N-1:0] mask;
    logic [7:0]   cnt;
    logic [1:0]   cnt2;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t m;
  logic [N*W-1:0] data;

  bus_mux_reg_if #(.WIDTH(W), .NUM_SRC(N), .CNT_W(8)) bif ();
  bus_mux_reg_if #(.WIDTH(W), .NUM_SRC(N), .CNT_W(2)) bif2 ();

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(N), .CNT_W(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif)
  );

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(N), .CNT_W(2)) dut2 (
    .clock (clock),
    .clear (clear),
    .bus   (bif2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic put(input int unsigned idx, input logic [W-1:0] word);
    data[idx*W +: W] = word;
  endtask

  // Drive one cycle, predict its result, then compare after the edge.
  task automatic step(input logic clr, input logic [N-1:0] en);
    exp_t e;
    clear         = clr;
    bif.src_en    = en;
    bif.src_data  = data;
    bif2.src_en   = en;
    bif2.src_data = data;
    if (clr) begin
      m = '{bus: '0, valid: 1'b0, sel: '0, conf: 1'b0, sticky: 1'b0, mask: '0, cnt: '0, cnt2: '0};
    end else begin
      m.valid = (en != '0);
      for (int i = 0; i < int'(N); i++) begin
        if (en[i]) begin
          m.bus = data[i*W +: W];
          m.sel = 5'(i);
        end
      end
`ifdef BUS_CONTENTION_CHECK_EN
      m.conf = ($countones(en) > 1);
      if (m.conf) begin
        if (!m.sticky) m.mask = en;
        m.sticky = 1'b1;
        if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
        if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
      end
`endif
    end
    q.push_back(m);
    @(posedge clock);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      chk("bus_out",         64'(bif.bus_out),         64'(e.bus));
      chk("bus_valid",       64'(bif.bus_valid),       64'(e.valid));
      chk("sel_idx",         64'(bif.sel_idx),         64'(e.sel));
      chk("conflict",        64'(bif.conflict),        64'(e.conf));
      chk("conflict_sticky", 64'(bif.conflict_sticky), 64'(e.sticky));
      chk("conflict_mask",   64'(bif.conflict_mask),   64'(e.mask));
      chk("conflict_count",  64'(bif.conflict_count),  64'(e.cnt));
      chk("bus_out_w2",      64'(bif2.bus_out),        64'(e.bus));
      chk("conflict_w2",     64'(bif2.conflict),       64'(e.conf));
      chk("count_w2",        64'(bif2.conflict_count), 64'(e.cnt2));
    end
  endtask

  initial begin
    logic [N-1:0] en;
    m = '{bus: '0, valid: 1'b0, sel: '0, conf: 1'b0, sticky: 1'b0, mask: '0, cnt: '0, cnt2: '0};
    for (int i = 0; i < int'(N); i++) put(i, $urandom());
    bif.src_en = '0;
    bif2.src_en = '0;

    // Reset with junk on the data lines.
    step(1'b1, '0);

    // Single source: PC.
    put(SRC_PC, 32'h0000_1234);
    en = '0; en[SRC_PC] = 1'b1;
    step(1'b0, en);

    // Hold for three idle cycles.
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    // Contention: R3 vs MDR, MDR wins.
    put(SRC_R3, 32'hAAAA_AAAA);
    put(SRC_MDR, 32'h5555_5555);
    en = '0; en[SRC_R3] = 1'b1; en[SRC_MDR] = 1'b1;
    step(1'b0, en);

    // Second conflict: mask must stay at the first one.
    en = '0; en[SRC_R0] = 1'b1; en[SRC_R1] = 1'b1;
    step(1'b0, en);

    // Five back-to-back conflicts saturate the narrow counter.
    en = '0; en[SRC_R2] = 1'b1; en[SRC_R5] = 1'b1; en[SRC_CSE] = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, en);

    // Random single-source loads across all sources, interleaved with idles.
    for (int i = 0; i < 12; i++) begin
      int unsigned s;
      s = $urandom_range(N - 1, 0);
      put(s, $urandom());
      en = '0; en[s] = 1'b1;
      step(1'b0, en);
      if (i % 3 == 0) step(1'b0, '0);
    end

    // Clear overrides a simultaneous load and conflict.
    put(SRC_CSE, 32'hFFFF_FFFF);
    en = '0; en[SRC_CSE] = 1'b1; en[SRC_R7] = 1'b1;
    step(1'b1, en);

    // First edge after clear loads normally.
    en = '0; en[SRC_CSE] = 1'b1;
    step(1'b0, en);
    step(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_mux_reg.md
# bus_mux_reg

Parametrised, registered successor to the datapath bus multiplexer. It selects one of `NUM_SRC` source words onto the shared CPU bus using per-source output-enable strobes, and registers the result so the bus settles on a clock edge. It holds the last driven value when no source is enabled and detects bus contention when more than one enable is asserted. It sits between the register file, HI/LO, Z, PC, MDR, InPort and CSE outputs and every bus-consuming register.

## Interface
Parameters:
- `WIDTH`, 32: bus word width in bits.
- `NUM_SRC`, 24: number of bus sources.
- `CNT_W`, 8: width of the contention event counter.

Ports:
- `clock`: input, 1 bit. Single clock; all state updates on its rising edge.
- `clear`: input, 1 bit. Synchronous reset, active-high.
- `src_en`: input, `NUM_SRC` bits. Per-source output-enable strobes; bit i enables source i.
- `src_data`: input, `NUM_SRC*WIDTH` bits. Flattened source words; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `bus_out`: output, `WIDTH` bits. Registered bus value.
- `bus_valid`: output, 1 bit. Registered; high when `bus_out` was loaded from a source on the last edge.
- `sel_idx`: output, `$clog2(NUM_SRC)` bits. Registered index of the source that won the last load.
- `conflict`: output, 1 bit. Registered; high for one cycle after a cycle in which two or more `src_en` bits were high.
- `conflict_sticky`: output, 1 bit. Set by any conflict and held until `clear`.
- `conflict_mask`: output, `NUM_SRC` bits. The `src_en` value captured at the first conflict since `clear`.
- `conflict_count`: output, `CNT_W` bits. Number of conflict cycles since `clear`; saturates.

## Operation
- Priority: when several enables are high, the highest-index enabled source wins. This keeps the legacy last-assignment-wins ordering.
- Load:
  - If any `src_en` bit is high, `bus_out` ← winner's word, `sel_idx` ← winner's index, `bus_valid` ← 1.
  - If no bit is high, `bus_out` and `sel_idx` hold their previous values and `bus_valid` ← 0. No latch, no X.
- Contention: a cycle counts as a conflict when the popcount of `src_en` is 2 or more. In that cycle:
  - `conflict` ← 1; otherwise `conflict` ← 0.
  - `conflict_sticky` ← 1.
  - `conflict_count` increments by 1, saturating at `2^CNT_W - 1`.
  - `conflict_mask` is loaded only when `conflict_sticky` was 0 before the edge, so it records the first offending mask.
- The load still happens on a conflict cycle, using the priority rule above.
- `clear` sets every output to 0: `bus_out`, `bus_valid`, `sel_idx`, `conflict`, `conflict_sticky`, `conflict_mask`, `conflict_count`.
- `clear` overrides a simultaneous load or conflict.
- Width rules: the selected word is passed through unmodified, with no sign or zero extension. `sel_idx` width is `$clog2(NUM_SRC)`, with a minimum of 1.

## Timing
- Latency is 1 cycle: enables and data sampled at edge N appear on `bus_out` after edge N.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Control units must assert `src_en` in the cycle before the consuming register's load enable.
- Reset taken mid-operation discards the value currently being loaded; the first post-reset edge with an enable loads normally.
- `conflict` is a single-cycle pulse per conflict cycle. Back-to-back conflict cycles give a continuous high and increment the count once per cycle.

## Configuration
- `BUS_CONTENTION_CHECK_EN` defined: popcount, `conflict`, `conflict_sticky`, `conflict_mask` and `conflict_count` logic are compiled in as described above.
- Not defined: these ports remain present but are tied to 0, and no counter or popcount logic is synthesised. Priority selection and hold behaviour are unchanged.

## Structure
- Shared package `bus_pkg` holds:
  - default `BUS_WIDTH` (32) and `BUS_NUM_SRC` (24);
  - source index constants `SRC_R0`…`SRC_R15` (0–15), `SRC_HI` (16), `SRC_LO` (17), `SRC_ZHIGH` (18), `SRC_ZLOW` (19), `SRC_PC` (20), `SRC_MDR` (21), `SRC_INPORT` (22), `SRC_CSE` (23).
- Sub-module `bus_prio_enc`: combinational highest-index priority encoder producing `any` and `idx` from `src_en`. Instantiated once.

## Test plan
- Reset: set `src_en`=0 and `src_data` to arbitrary values, assert `clear` for 1 cycle → all outputs 0 on the next cycle.
- Single source: `src_en`=bit 20 (PC), PC word 0x0000_1234 → next cycle `bus_out`=0x0000_1234, `sel_idx`=20, `bus_valid`=1, `conflict`=0.
- Hold: after the previous step, `src_en`=0 for 3 cycles → `bus_out` stays 0x0000_1234, `bus_valid`=0, `sel_idx`=20.
- Contention (macro on): `src_en`=bits 3 and 21, R3=0xAAAA_AAAA, MDR=0x5555_5555 → `bus_out`=0x5555_5555, `sel_idx`=21, `conflict`=1, `conflict_sticky`=1, `conflict_mask`=0x20_0008, `conflict_count`=1.
  - A second conflict with bits 0 and 1 → `conflict_count`=2, `conflict_mask` unchanged.
- Saturation: with `CNT_W`=2, 5 consecutive conflict cycles → `conflict_count` reaches 3 and stays 3.
- Reset versus load: assert `clear` and `src_en`=bit 23 (CSE) with data 0xFFFF_FFFF in the same cycle → `bus_out`=0, `bus_valid`=0.
  - Repeat with the macro undefined and a conflict applied → all `conflict*` outputs remain 0.
